// File: rtl/cram_backup_ctrl.sv
// cram_backup_ctrl: streams cartridge RAM to/from 512-byte save-file sectors on idle cycles of the shared cart RAM port.
//
// Ports:
//   clk_sys, reset_n                      system clock, asynchronous active-low reset
//   ce_cpu                                CPU cycle; the CPU owns the RAM port whenever it is high
//   has_ram, mbc2_mode, ram_mask          cartridge RAM description (MBC2 nibble RAM, 1-4 banks of 8 KB)
//   cpu_cram_addr/_wr/_di                 CPU side of the RAM port
//   cram_addr/_wr/_wdata, cram_rdata      shared RAM port (read data one cycle after the address)
//   save_req, load_req, busy, done        transfer control and status
//   bk_lba, bk_wr, bk_rd, bk_ack          sector request handshake with the host
//   bk_dout/_valid/_ready                 save byte stream towards the host
//   bk_din/_valid/_ready                  load byte stream from the host
`timescale 1ns/1ps
module cram_backup_ctrl (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_cpu,
    input  logic        has_ram,
    input  logic        mbc2_mode,
    input  logic [1:0]  ram_mask,
    input  logic [16:0] cpu_cram_addr,
    input  logic        cpu_cram_wr,
    input  logic [7:0]  cpu_cram_di,
    output logic [16:0] cram_addr,
    output logic        cram_wr,
    output logic [7:0]  cram_wdata,
    input  logic [7:0]  cram_rdata,
    input  logic        save_req,
    input  logic        load_req,
    output logic        busy,
    output logic        done,
    output logic [5:0]  bk_lba,
    output logic        bk_wr,
    output logic        bk_rd,
    input  logic        bk_ack,
    output logic [7:0]  bk_dout,
    output logic        bk_dout_valid,
    input  logic        bk_dout_ready,
    input  logic [7:0]  bk_din,
    input  logic        bk_din_valid,
    output logic        bk_din_ready
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_ACKW, S_DONE} state_t;

    state_t     state;
    logic [5:0] sector;
    logic [8:0] byte_idx;
    logic       saving;
    logic       rd_pend;
    logic [5:0] last_sector;
    logic       in_xfer;
    logic       save_hs;
    logic       load_hs;
    logic       rd_issue;
    logic [8:0] eng_byte;
    logic [7:0] eng_wdata;

    assign last_sector  = mbc2_mode ? 6'd0 : {ram_mask, 4'hF};
    assign in_xfer      = state == S_XFER;
    assign save_hs      = in_xfer && saving && bk_dout_valid && bk_dout_ready;
    assign bk_din_ready = in_xfer && !saving && bk_ack && !ce_cpu;
    assign load_hs      = bk_din_valid && bk_din_ready;
    // The next read may overlap the handshake of the current byte, giving
    // one byte every two engine cycles when the host never stalls.
    assign rd_issue     = in_xfer && saving && bk_ack && !ce_cpu && !rd_pend &&
                          (!bk_dout_valid || (save_hs && byte_idx != 9'd511));
    assign eng_byte     = bk_dout_valid ? byte_idx + 9'd1 : byte_idx;
    assign eng_wdata    = load_hs ? (mbc2_mode ? {4'hF, bk_din[3:0]} : bk_din) : 8'h00;
    assign bk_lba       = sector;

    // CPU has strict priority; its writes are masked while a load restores RAM.
    always_comb begin
        cram_addr  = ce_cpu ? cpu_cram_addr : {2'b00, sector, eng_byte};
        cram_wr    = ce_cpu ? (cpu_cram_wr && !(busy && !saving)) : load_hs;
        cram_wdata = ce_cpu ? cpu_cram_di : eng_wdata;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            sector        <= 6'd0;
            byte_idx      <= 9'd0;
            saving        <= 1'b0;
            rd_pend       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bk_wr         <= 1'b0;
            bk_rd         <= 1'b0;
            bk_dout       <= 8'h00;
            bk_dout_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (save_req || load_req) begin
                        if (!has_ram) begin
                            done <= 1'b1;
                        end else begin
                            busy   <= 1'b1;
                            saving <= save_req;
                            sector <= 6'd0;
                            bk_wr  <= save_req;
                            bk_rd  <= !save_req;
                            state  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bk_ack) begin
                        bk_wr         <= 1'b0;
                        bk_rd         <= 1'b0;
                        byte_idx      <= 9'd0;
                        rd_pend       <= 1'b0;
                        bk_dout_valid <= 1'b0;
                        state         <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!bk_ack) begin
                        // host abandoned the sector: abort without completion
                        state         <= S_IDLE;
                        busy          <= 1'b0;
                        bk_dout_valid <= 1'b0;
                        rd_pend       <= 1'b0;
                    end else begin
                        // read data arrives one cycle after the address,
                        // even if that cycle belongs to the CPU
                        if (rd_pend) begin
                            bk_dout       <= mbc2_mode ? {4'hF, cram_rdata[3:0]} : cram_rdata;
                            bk_dout_valid <= 1'b1;
                        end else if (save_hs) begin
                            bk_dout_valid <= 1'b0;
                        end
                        rd_pend <= rd_issue;
                        if (save_hs || load_hs) begin
                            byte_idx <= byte_idx + 9'd1;
                            if (byte_idx == 9'd511) state <= S_ACKW;
                        end
                    end
                end
                S_ACKW: begin
                    if (!bk_ack) begin
                        if (sector == last_sector) begin
                            state <= S_DONE;
                        end else begin
                            sector <= sector + 6'd1;
                            bk_wr  <= saving;
                            bk_rd  <= !saving;
                            state  <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cram_backup_ctrl.sv
// tb_cram_backup_ctrl: directed vector and sequence bench for cram_backup_ctrl with a behavioural cart RAM and sector host.
`timescale 1ns/1ps
module tb_cram_backup_ctrl;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_cpu = 1'b0;
    logic        has_ram = 1'b0;
    logic        mbc2_mode = 1'b0;
    logic [1:0]  ram_mask = 2'd0;
    logic [16:0] cpu_cram_addr = '0;
    logic        cpu_cram_wr = 1'b0;
    logic [7:0]  cpu_cram_di = '0;
    logic [16:0] cram_addr;
    logic        cram_wr;
    logic [7:0]  cram_wdata;
    logic [7:0]  cram_rdata = '0;
    logic        save_req = 1'b0;
    logic        load_req = 1'b0;
    logic        busy;
    logic        done;
    logic [5:0]  bk_lba;
    logic        bk_wr;
    logic        bk_rd;
    logic        bk_ack = 1'b0;
    logic [7:0]  bk_dout;
    logic        bk_dout_valid;
    logic        bk_dout_ready = 1'b0;
    logic [7:0]  bk_din = '0;
    logic        bk_din_valid = 1'b0;
    logic        bk_din_ready;

    cram_backup_ctrl dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu), .has_ram(has_ram),
        .mbc2_mode(mbc2_mode), .ram_mask(ram_mask),
        .cpu_cram_addr(cpu_cram_addr), .cpu_cram_wr(cpu_cram_wr), .cpu_cram_di(cpu_cram_di),
        .cram_addr(cram_addr), .cram_wr(cram_wr), .cram_wdata(cram_wdata), .cram_rdata(cram_rdata),
        .save_req(save_req), .load_req(load_req), .busy(busy), .done(done),
        .bk_lba(bk_lba), .bk_wr(bk_wr), .bk_rd(bk_rd), .bk_ack(bk_ack),
        .bk_dout(bk_dout), .bk_dout_valid(bk_dout_valid), .bk_dout_ready(bk_dout_ready),
        .bk_din(bk_din), .bk_din_valid(bk_din_valid), .bk_din_ready(bk_din_ready)
    );

    always #5 clk_sys = ~clk_sys;

    bit         vld [0:131071];
    logic [7:0] mem [0:131071];

    function automatic logic [7:0] pat(input int a);
        return 8'(a + (a >> 9) * 13);
    endfunction

    function automatic logic [7:0] model(input int a);
        return vld[a] ? mem[a] : pat(a);
    endfunction

    always @(posedge clk_sys) begin
        if (cram_wr) begin
            mem[cram_addr] <= cram_wdata;
            vld[cram_addr] <= 1'b1;
        end
        cram_rdata <= model(int'(cram_addr));
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic rst_dut();
        @(negedge clk_sys);
        reset_n = 1'b0; save_req = 0; load_req = 0; bk_ack = 0; bk_dout_ready = 0;
        bk_din_valid = 0; ce_cpu = 0; cpu_cram_wr = 0;
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    // Runs one whole save or load as the sector host, checking every byte.
    task automatic host_run(input bit save, input int nsec, input bit ce_tog,
                            input int bp_at, input int rst_at, input bit cpu_wr);
        int s = 0, b = 0, phase = 0, cyc = 0, bp = 0, dones = 0, since = 0, p1 = 0;
        bit have_held = 0, fin = 0;
        logic [7:0] held = 0, want;
        @(negedge clk_sys);
        has_ram = 1; save_req = save; load_req = !save;
        @(negedge clk_sys);
        save_req = 0; load_req = 0;
        while (!fin) begin
            @(negedge clk_sys);
            cyc++;
            ce_cpu = ce_tog && (cyc % 2 == 0);
            cpu_cram_addr = 17'($urandom);
            cpu_cram_di = 8'($urandom);
            cpu_cram_wr = cpu_wr && ce_cpu && phase == 1;
            if (cpu_cram_wr) cpu_cram_addr = 17'h10000;
            bk_ack = phase == 1;
            bk_dout_ready = save && phase == 1 && bp == 0;
            bk_din_valid = !save && phase == 1;
            bk_din = 8'(s * 512 + b);
            if (phase == 1 && s * 512 + b == rst_at) begin
                ce_cpu = 0; cpu_cram_wr = 0; reset_n = 0;
                #2;
                chk("reset_mid_outputs", {busy, done, bk_wr, bk_rd, bk_lba, bk_dout, bk_dout_valid,
                    bk_din_ready, cram_addr, cram_wr, cram_wdata}, 64'd0);
                bk_ack = 0; bk_dout_ready = 0; bk_din_valid = 0;
                @(negedge clk_sys);
                reset_n = 1;
                return;
            end
            #2;
            if (ce_cpu)
                chk("cpu_owns_port", {cram_addr, cram_wr, cram_wdata},
                    {cpu_cram_addr, save ? cpu_cram_wr : 1'b0, cpu_cram_di});
            if (done) dones++;
            if (phase == 0) begin
                if (bk_wr || bk_rd) begin
                    chk("req_kind", {bk_wr, bk_rd}, {save, !save});
                    chk("req_lba", bk_lba, s);
                    phase = 1; p1 = 0;
                end
            end else if (phase == 1) begin
                if (save) begin
                    if (bp > 0) begin
                        bp--;
                        if (bk_dout_valid && !have_held) begin
                            held = bk_dout; have_held = 1;
                        end else if (have_held) begin
                            chk("bp_stable", {bk_dout_valid, bk_dout}, {1'b1, held});
                        end
                    end else if (bk_dout_valid && bk_dout_ready) begin
                        want = model(s * 512 + b);
                        if (mbc2_mode) want = {4'hF, want[3:0]};
                        chk("save_byte", bk_dout, want);
                        b++;
                        if (s * 512 + b == bp_at) begin bp = 20; have_held = 0; end
                    end
                end else begin
                    if (p1 > 0) chk("din_ready_engine_only", bk_din_ready, !ce_cpu);
                    if (bk_din_ready) begin
                        chk("load_write", {cram_wr, cram_addr, cram_wdata}, {1'b1, 17'(s * 512 + b), bk_din});
                        b++;
                    end
                end
                p1++;
                if (b == 512) phase = 2;
            end else if (phase == 2) begin
                s++; b = 0; since = 0;
                phase = (s == nsec) ? 3 : 0;
            end else begin
                since++;
                if (done) chk("done_latency", since, 2);
                if (since >= 6) fin = 1;
            end
            if (cyc > 40000) begin
                n_checks++; n_fail++;
                $display("FAIL host_timeout: phase %0d sector %0d byte %0d, required completion", phase, s, b);
                fin = 1;
            end
        end
        ce_cpu = 0; cpu_cram_wr = 0;
        chk("done_count", dones, 1);
        chk("busy_after_done", busy, 0);
    endtask

    typedef struct {
        logic        ce;
        logic [16:0] addr;
        logic        wr;
        logic [7:0]  di;
        logic [16:0] e_addr;
        logic        e_wr;
        logic [7:0]  e_di;
    } mux_vec_t;

    typedef struct {
        logic has;
        logic sv;
        logic ld;
        logic e_wr;
        logic e_rd;
        logic e_done;
        logic e_busy;
    } req_vec_t;

    mux_vec_t mux_tab [4];
    req_vec_t req_tab [6];

    initial begin
        mux_tab[0] = '{1'b1, 17'h1ABCD, 1'b1, 8'h5A, 17'h1ABCD, 1'b1, 8'h5A};
        mux_tab[1] = '{1'b1, 17'h00123, 1'b0, 8'hFF, 17'h00123, 1'b0, 8'hFF};
        mux_tab[2] = '{1'b0, 17'h1FFFF, 1'b1, 8'h33, 17'h00000, 1'b0, 8'h00};
        mux_tab[3] = '{1'b1, 17'h10000, 1'b1, 8'h80, 17'h10000, 1'b1, 8'h80};
        req_tab[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        req_tab[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        req_tab[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        req_tab[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        req_tab[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        req_tab[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (2) @(negedge clk_sys);
        #2;
        chk("reset_state", {busy, done, bk_wr, bk_rd, bk_lba, bk_dout, bk_dout_valid,
            bk_din_ready, cram_addr, cram_wr, cram_wdata}, 64'd0);
        reset_n = 1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            ce_cpu = mux_tab[i].ce; cpu_cram_addr = mux_tab[i].addr;
            cpu_cram_wr = mux_tab[i].wr; cpu_cram_di = mux_tab[i].di;
            #2;
            chk($sformatf("port_mux[%0d]", i), {cram_addr, cram_wr, cram_wdata},
                {mux_tab[i].e_addr, mux_tab[i].e_wr, mux_tab[i].e_di});
        end
        ce_cpu = 0; cpu_cram_wr = 0;

        for (int i = 0; i < 6; i++) begin
            rst_dut();
            @(negedge clk_sys);
            has_ram = req_tab[i].has; save_req = req_tab[i].sv; load_req = req_tab[i].ld;
            @(negedge clk_sys);
            save_req = 0; load_req = 0;
            #2;
            chk($sformatf("req_start[%0d]", i), {bk_wr, bk_rd, done, busy},
                {req_tab[i].e_wr, req_tab[i].e_rd, req_tab[i].e_done, req_tab[i].e_busy});
            @(negedge clk_sys);
            #2;
            chk($sformatf("req_next[%0d]", i), {bk_wr, bk_rd, done},
                {req_tab[i].e_wr, req_tab[i].e_rd, 1'b0});
        end
        rst_dut();

        mbc2_mode = 1;
        host_run(1'b1, 1, 1'b0, -1, -1, 1'b0);
        mbc2_mode = 0;

        ram_mask = 2'd0;
        host_run(1'b1, 16, 1'b1, 512 + 200, -1, 1'b0);

        host_run(1'b1, 16, 1'b0, -1, 3 * 512 + 100, 1'b0);
        host_run(1'b1, 16, 1'b0, -1, 5, 1'b0);

        @(negedge clk_sys);
        save_req = 1;
        @(negedge clk_sys);
        save_req = 0;
        #2;
        chk("abort_req", bk_wr, 1);
        @(negedge clk_sys);
        bk_ack = 1; bk_dout_ready = 1;
        repeat (10) @(negedge clk_sys);
        bk_ack = 0;
        #2;
        chk("abort_busy_before", busy, 1);
        @(negedge clk_sys);
        #2;
        chk("abort_idle", {busy, bk_dout_valid, bk_wr, done}, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            #2;
            chk("abort_no_done", done, 0);
        end
        bk_dout_ready = 0;

        ram_mask = 2'd1;
        host_run(1'b0, 32, 1'b1, -1, -1, 1'b1);
        chk("load_0x2A05", model(32'h2A05), 8'h05);
        chk("load_0x3FFF", model(32'h3FFF), 8'hFF);
        chk("load_0x0000", model(32'h0000), 8'h00);
        chk("load_range_end", model(32'h4000), pat(32'h4000));
        chk("cpu_wr_dropped", model(32'h10000), pat(32'h10000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cram_backup_ctrl.md
# cram_backup_ctrl

Sequences battery-save backup of cartridge RAM between the cart RAM port and the save-file sector interface, sharing the single cart RAM port with the CPU. It streams whole 512-byte sectors out on save or in on load. The CPU keeps strict priority: it owns the port on every `ce_cpu` cycle, and the engine uses only idle cycles. It sits between the active mapper's cart RAM path and the RAM backing store, handling MBC2 4-bit RAM and 1–4 bank RAM sizes.

## Interface
No parameters.
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce_cpu` in 1: CPU clock enable. At most one high cycle in any two.
- `has_ram` in 1: cart has battery-backed RAM.
- `mbc2_mode` in 1: 512x4-bit RAM.
- `ram_mask` in 2: bank count minus 1, giving 1–4 banks of 8 KB.
- `cpu_cram_addr` in 17, `cpu_cram_wr` in 1, `cpu_cram_di` in 8: CPU access.
- `cram_addr` out 17, `cram_wr` out 1, `cram_wdata` out 8: RAM port.
- `save_req`, `load_req` in 1: single-cycle start pulses.
- `busy` out 1: engine active. `done` out 1: single-cycle completion pulse.
- `bk_lba` out 6: current sector. `bk_wr` out 1, `bk_rd` out 1: sector write/read request. `bk_ack` in 1: host owns sector.
- `bk_dout` out 8, `bk_dout_valid` out 1, `bk_dout_ready` in 1: save stream.
- `bk_din` in 8, `bk_din_valid` in 1, `bk_din_ready` out 1: load stream.
- `cram_rdata` in 8: RAM read data, valid one cycle after the address.

## Operation
- **Reset values.** All outputs are 0. State is IDLE and the sector and byte counters are 0.
- **Port mux.**
  - When `ce_cpu`=1, the CPU address, write and data drive the port.
  - Otherwise the engine drives the port.
  - During a load, `cpu_cram_wr` is ignored so the CPU cannot corrupt the restore.
- **Engine address.** `{2'b0, sector[5:0], byte[8:0]}`.
- **Last sector index.** 0 if `mbc2_mode`, else `16*(ram_mask+1)-1`. This gives 0, 15, 31, 47 or 63.
- **Starting a transfer.**
  - Starts only in IDLE.
  - `save_req` and `load_req` in the same cycle: save wins and the load is dropped.
  - Requests while busy are ignored.
  - A request with `has_ram`=0 pulses `done` the next cycle and starts no transfer.
- **State machine.**
  - IDLE: on a request, `busy`=1, sector=0, go to REQ.
  - REQ: assert `bk_wr` (save) or `bk_rd` (load), `bk_lba`=sector. Hold until `bk_ack`=1, then deassert the request, byte=0, go to XFER.
  - XFER, save: on an engine cycle with `bk_dout_valid`=0 and no read in flight, present the address. On the next cycle, capture `cram_rdata` into `bk_dout` and set valid.
    - MBC2: `bk_dout` = `{4'hF, rdata[3:0]}`.
    - Valid holds until `bk_dout_ready`. On the handshake, byte increments.
  - XFER, load: `bk_din_ready`=1 only on engine cycles, i.e. `ce_cpu`=0. On valid&ready, `cram_wr`=1, `cram_wdata` = `bk_din` (MBC2: `{4'hF, bk_din[3:0]}`), and byte increments.
  - Leaving XFER: after byte 511 completes, go to ACKW.
  - ACKW: wait for `bk_ack`=0.
    - If sector = last, go to DONE.
    - Otherwise sector increments and go to REQ.
  - DONE: `done`=1 for one cycle, `busy`=0, go to IDLE.
- **Save snapshot.** CPU writes during a save are allowed. Sectors not yet read reflect them, so the snapshot is not atomic.
- **Reset mid-transfer.** All state clears immediately and nothing more is written. The host sees `bk_wr`/`bk_rd` and `bk_dout_valid` drop.
- **`bk_ack` drops early in XFER.** Protocol error: go to IDLE with `busy`=0 and no `done` pulse.

## Timing
- **Request latency.** The request pulse to `bk_wr`/`bk_rd` high is 1 cycle.
- **Save read path.** Engine address to `bk_dout_valid` is 1 cycle.
- **`ce_cpu` during the read data cycle.** The read data cycle may coincide with `ce_cpu`=1. Capture still occurs, because the read was issued on the prior engine cycle.
- **Load write.** The RAM write happens in the handshake cycle. It is never in a `ce_cpu` cycle.
- **Best-case throughput.**
  - Save: 1 byte per 2 cycles with `ce_cpu`=0 and ready held high.
  - Load: 1 byte per cycle.
- **Completion.** `done` follows the final `bk_ack` fall by 2 cycles: ACKW, then DONE.

## Test plan
- **MBC2 save.** `mbc2_mode`=1, RAM pre-filled so byte i holds i & 0xF, `save_req`, ready always 1 → one sector, `bk_lba`=0, 512 bytes `{F, i[3:0]}`, then one `done`.
- **Multi-sector load.** `ram_mask`=1 load, host streams sector*512+byte low 8 bits → 32 sectors requested 0..31. RAM byte 0x2A05 = 0x05. `done` once.
- **CPU priority.** `ce_cpu` toggling every 2 cycles during a save → `cram_addr` equals `cpu_cram_addr` on every `ce_cpu` cycle and no stream byte is lost or duplicated. A CPU write during the load is dropped.
- **Simultaneous starts and absent RAM.**
  - `save_req` and `load_req` in the same cycle → `bk_wr` only.
  - A request with `has_ram`=0 → `done` the next cycle, `bk_wr`/`bk_rd` stay 0.
- **Backpressure.** `bk_dout_ready` low for 20 cycles mid-sector → `bk_dout` is stable and no new RAM read is issued.
- **Reset mid-transfer.** `reset_n` low at byte 100 of sector 3 → all outputs 0 the same cycle. A fresh save after reset starts at `bk_lba`=0.
